datapath_pipe: RTL and testbench

DATAPATH_PIPE -- requirements
Module: datapath_pipe

---
 rtl/datapath_pipe.sv | 199 +++++++++++++++++++
 tb/tb_datapath_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// Multi-cycle register-file datapath: accept, execute (1 cycle, or one bit per cycle for shifts), publish.
// Optional status flags are enabled by defining DP_STATUS_FLAGS_EN; otherwise V/C/N/Z are tied to zero.
module datapath_pipe #(
  parameter int              WIDTH    = 16,
  parameter int              NREG     = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(32'd3)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NREG)-1:0]   DA,
  input  logic [$clog2(NREG)-1:0]   AA,
  input  logic [$clog2(NREG)-1:0]   BA,
  input  logic [3:0]                FS,
  input  logic                      MB,
  input  logic                      MD,
  input  logic                      RW,
  input  logic [WIDTH-1:0]          const_in,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [$clog2(WIDTH)-1:0]  sh,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          result,
  output logic [WIDTH-1:0]          addr_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      V,
  output logic                      C,
  output logic                      N,
  output logic                      Z
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] FS_SHR = 4'b1101;
  localparam logic [3:0] FS_SHL = 4'b1110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_a, r_b, r_shv, r_din;
  logic [SW-1:0]    r_cnt;
  logic [3:0]       r_fs;
  logic             r_md, r_rw;
  logic [AW-1:0]    r_da;
  logic             w_accept, w_is_shift, w_exec_last, w_cin;
  logic [WIDTH-1:0] w_y, w_f, w_shift_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result, r_addr_out, r_data_out;

  assign w_accept    = in_valid & (r_state == S_IDLE);
  assign w_is_shift  = (r_fs == FS_SHR) | (r_fs == FS_SHL);
  // r_cnt counts remaining shift steps; the final step is folded into w_f on the last EXEC cycle.
  assign w_exec_last = (r_state == S_EXEC) & (~w_is_shift | (r_cnt <= SW'(1)));
  assign w_shift_nxt = (r_fs == FS_SHR) ? (r_shv >> 1'b1) : (r_shv << 1'b1);
  assign in_ready    = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_EXEC : S_IDLE;
      S_EXEC:  w_state_nxt = w_exec_last ? S_DONE : S_EXEC;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_shv <= '0;
      r_din <= '0;
      r_cnt <= '0;
      r_fs  <= '0;
      r_md  <= 1'b0;
      r_rw  <= 1'b0;
      r_da  <= '0;
    end else if (w_accept) begin
      r_a   <= r_regs[AA];
      r_b   <= MB ? const_in : r_regs[BA];
      r_shv <= MB ? const_in : r_regs[BA];
      r_din <= data_in;
      r_cnt <= sh;
      r_fs  <= FS;
      r_md  <= MD;
      r_rw  <= RW;
      r_da  <= DA;
    end else if ((r_state == S_EXEC) && w_is_shift && !w_exec_last) begin
      r_shv <= w_shift_nxt;
      r_cnt <= r_cnt - SW'(1);
    end
  end

  always_comb begin
    w_y   = '0;
    w_cin = 1'b0;
    case (r_fs)
      4'b0001: w_cin = 1'b1;
      4'b0010: w_y   = r_b;
      4'b0011: begin w_y = r_b;  w_cin = 1'b1; end
      4'b0100: w_y   = ~r_b;
      4'b0101: begin w_y = ~r_b; w_cin = 1'b1; end
      4'b0110: w_y   = '1;
      default: begin w_y = '0;   w_cin = 1'b0; end
    endcase
  end

`ifdef DP_STATUS_FLAGS_EN
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
`else
  logic [WIDTH-1:0] w_sum;
  assign w_sum = r_a + w_y + {{(WIDTH-1){1'b0}}, w_cin};
`endif

  always_comb begin
    w_f = r_a;
    case (r_fs)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110: w_f = w_sum[WIDTH-1:0];
      4'b1000: w_f = r_a & r_b;
      4'b1001: w_f = r_a | r_b;
      4'b1010: w_f = r_a ^ r_b;
      4'b1011: w_f = ~r_a;
      4'b1100: w_f = r_b;
      4'b1101, 4'b1110: w_f = (r_cnt != '0) ? w_shift_nxt : r_shv;
      default: w_f = r_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= INIT_VAL;
    end else if (w_exec_last && r_rw) begin
      r_regs[r_da] <= r_md ? r_din : w_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_addr_out  <= '0;
      r_data_out  <= '0;
    end else begin
      r_out_valid <= (r_state == S_DONE);
      if (w_exec_last) begin
        r_result   <= w_f;
        r_addr_out <= r_a;
        r_data_out <= r_b;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign addr_out  = r_addr_out;
  assign data_out  = r_data_out;

`ifdef DP_STATUS_FLAGS_EN
  logic w_arith, w_c, w_v;
  logic r_v, r_c, r_n, r_z;
  // Only A, A+1, the add/subtract family and A-1 produce carry and overflow.
  assign w_arith = ~r_fs[3] & (r_fs != 4'b0111);
  assign w_c     = w_arith & w_sum[WIDTH];
  assign w_v     = w_arith & (r_a[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_c <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (w_exec_last) begin
      r_v <= w_v;
      r_c <= w_c;
      r_n <= w_f[WIDTH-1];
      r_z <= (w_f == '0);
    end
  end

  assign V = r_v;
  assign C = r_c;
  assign N = r_n;
  assign Z = r_z;
`else
  assign V = 1'b0;
  assign C = 1'b0;
  assign N = 1'b0;
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: expected records are queued at accept and matched against completions.
module tb_datapath_pipe;

  localparam logic [15:0] INIT = 16'h0003;
`ifdef DP_STATUS_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
  logic [2:0]  DA = 3'd0, AA = 3'd0, BA = 3'd0;
  logic [3:0]  FS = 4'd0, sh = 4'd0;
  logic        MB = 1'b0, MD = 1'b0, RW = 1'b0;
  logic [15:0] const_in = 16'h0000, data_in = 16'h0000;
  logic        out_valid, V, C, N, Z;
  logic [15:0] result, addr_out, data_out;

  datapath_pipe #(.WIDTH(16), .NREG(8), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .MD(MD), .RW(RW),
    .const_in(const_in), .data_in(data_in), .sh(sh),
    .out_valid(out_valid), .result(result), .addr_out(addr_out), .data_out(data_out),
    .V(V), .C(C), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] ad;
    logic [15:0] dd;
    logic [3:0]  fl;
    logic [31:0] cyc;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [15:0] m_regs [8];
  logic [31:0] cyc = 32'd0;
  int          checks = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk)
    if (rst_n === 1'b1 && out_valid === 1'b1)
      obs_q.push_back({result, addr_out, data_out, {V, C, N, Z}, cyc});

  function automatic void model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] shv, output logic [15:0] f, output logic [3:0] fl);
    logic [15:0] y;
    int          cin, ss;
    int unsigned s;
    bit          arith, c, v;
    arith = 1'b1; y = 16'h0000; cin = 0; c = 1'b0; v = 1'b0; f = a;
    case (fs)
      4'd0: begin y = 16'h0000; cin = 0; end
      4'd1: begin y = 16'h0000; cin = 1; end
      4'd2: begin y = b;        cin = 0; end
      4'd3: begin y = b;        cin = 1; end
      4'd4: begin y = ~b;       cin = 0; end
      4'd5: begin y = ~b;       cin = 1; end
      4'd6: begin y = 16'hFFFF; cin = 0; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      s  = 32'(a) + 32'(y) + 32'(cin);
      f  = s[15:0];
      c  = s[16];
      ss = int'($signed(a)) + int'($signed(y)) + cin;
      v  = (ss > 32767) || (ss < -32768);
    end else begin
      case (fs)
        4'd8:    f = a & b;
        4'd9:    f = a | b;
        4'd10:   f = a ^ b;
        4'd11:   f = ~a;
        4'd12:   f = b;
        4'd13:   f = b >> shv;
        4'd14:   f = b << shv;
        default: f = a;
      endcase
    end
    fl = FLAGS ? {v, c, f[15], (f == 16'h0000)} : 4'b0000;
  endfunction

  task automatic send(input logic [3:0] fs, input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                      input logic mb, input logic md, input logic rw, input logic [15:0] cst,
                      input logic [15:0] din, input logic [3:0] shv, input bit push);
    logic [15:0] a, b, f;
    logic [3:0]  fl;
    int          n, w;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      checks++;
      $display("FAIL in_ready_wait: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    FS = fs; DA = da; AA = aa; BA = ba; MB = mb; MD = md; RW = rw;
    const_in = cst; data_in = din; sh = shv; in_valid = 1'b1;
    a = m_regs[aa];
    b = mb ? cst : m_regs[ba];
    model(fs, a, b, shv, f, fl);
    n = ((fs == 4'd13 || fs == 4'd14) && shv > 4'd1) ? int'(shv) : 1;
    if (push) begin
      exp_q.push_back({f, a, b, fl, cyc + 32'd1 + 32'(n) + 32'd1});
      if (rw) m_regs[da] = md ? din : f;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_obs(output rec_t o, output bit ok);
    int w;
    w = 0;
    while (obs_q.size() == 0 && w < 100) begin @(negedge clk); #1; w++; end
    ok = (obs_q.size() > 0);
    o  = ok ? obs_q.pop_front() : '0;
  endtask

  task automatic readback_all(input string tag);
    rec_t o, e;
    bit   ok;
    for (int r = 0; r < 8; r++) begin
      send(4'd0, 3'd0, 3'(r), 3'(r), 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
      get_obs(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e)
        $display("FAIL %s_R%0d: got res=%h a=%h b=%h vcnz=%b cyc=%0d ok=%0d, want res=%h a=%h b=%h vcnz=%b cyc=%0d",
                 tag, r, o.res, o.ad, o.dd, o.fl, o.cyc, ok, e.res, e.ad, e.dd, e.fl, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_reset();
    for (int r = 0; r < 8; r++) m_regs[r] = INIT;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, result, addr_out, data_out, V, C, N, Z} !== 53'd0)
      $display("FAIL reset_outputs: got ov=%b res=%h a=%h b=%h vcnz=%b%b%b%b, required all 0",
               out_valid, result, addr_out, data_out, V, C, N, Z);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else passed++;
    readback_all("init");
  endtask

  task automatic test_scenarios();
    rec_t o, e;
    bit   ok;
    send(4'd2, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b1);  // R3 = R1 + R2
    send(4'd0, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);  // read R3
    send(4'd5, 3'd7, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b1);  // A - A
    send(4'd0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h7FFF, 4'd0, 1'b1);  // load R4
    send(4'd1, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);  // 0x7FFF + 1
    for (int i = 0; i < 5; i++) begin
      get_obs(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e)
        $display("FAIL scenario%0d: got res=%h a=%h b=%h vcnz=%b cyc=%0d ok=%0d, want res=%h a=%h b=%h vcnz=%b cyc=%0d",
                 i, o.res, o.ad, o.dd, o.fl, o.cyc, ok, e.res, e.ad, e.dd, e.fl, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_shift();
    rec_t o, e;
    bit   ok;
    send(4'd14, 3'd6, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, 4'd4, 1'b1);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL shift_busy: in_ready=%b, required 0 during EXEC", in_ready);
    else passed++;
    send(4'd13, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000, 4'd0, 1'b1);
    send(4'd13, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'hF000, 16'h0000, 4'd3, 1'b1);
    send(4'd14, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h00F1, 16'h0000, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      get_obs(o, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || o !== e)
        $display("FAIL shift%0d: got res=%h a=%h b=%h vcnz=%b cyc=%0d ok=%0d, want res=%h a=%h b=%h vcnz=%b cyc=%0d",
                 i, o.res, o.ad, o.dd, o.fl, o.cyc, ok, e.res, e.ad, e.dd, e.fl, e.cyc);
      else passed++;
    end
  endtask

  task automatic test_rw0();
    rec_t o, e;
    bit   ok;
    send(4'd2, 3'd2, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1);
    get_obs(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o.ad !== 16'h0003 || o.dd !== 16'h0003 || o !== e)
      $display("FAIL rw0: got res=%h a=%h b=%h vcnz=%b cyc=%0d ok=%0d, want res=%h a=%h b=%h vcnz=%b cyc=%0d",
               o.res, o.ad, o.dd, o.fl, o.cyc, ok, e.res, e.ad, e.dd, e.fl, e.cyc);
    else passed++;
    readback_all("rw0");
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    bit   ok;
    int   n;
    n = 0;
    for (int i = 0; i < 24; i++) begin
      send(4'($urandom_range(15, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
           3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom), 4'($urandom_range(5, 0)), 1'b1);
      n++;
      if (n == 3 || i == 23) begin
        for (int j = 0; j < n; j++) begin
          get_obs(o, ok);
          e = exp_q.pop_front();
          checks++;
          if (!ok || o !== e)
            $display("FAIL b2b%0d: got res=%h a=%h b=%h vcnz=%b cyc=%0d ok=%0d, want res=%h a=%h b=%h vcnz=%b cyc=%0d",
                     i, o.res, o.ad, o.dd, o.fl, o.cyc, ok, e.res, e.ad, e.dd, e.fl, e.cyc);
          else passed++;
        end
        n = 0;
      end
    end
    readback_all("b2b");
  endtask

  task automatic test_abort();
    send(4'd14, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 4'd10, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int r = 0; r < 8; r++) m_regs[r] = INIT;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, result, addr_out, data_out, V, C, N, Z} !== 53'd0)
      $display("FAIL abort_outputs: got ov=%b res=%h a=%h b=%h, required all 0", out_valid, result, addr_out, data_out);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b, required 1", in_ready);
    else passed++;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) $display("FAIL abort_no_out_valid: got %0d completions, required 0", obs_q.size());
    else passed++;
    readback_all("abort");
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_shift();
    test_rw0();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
